// File: rtl/object_draw_pkg.sv
// Shared definitions for the sprite drawer: FSM states, screen bounds and coordinate widths.
package object_draw_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;

    // Sized copies of the screen bounds, one bit wider than the coordinates so
    // an unclipped origin+offset sum compares without wrapping.
    localparam logic [X_W:0] X_END = SCREEN_W[X_W:0];
    localparam logic [Y_W:0] Y_END = SCREEN_H[Y_W:0];

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAW,
        ST_FLUSH,
        ST_DONE
    } draw_state_e;

    function automatic logic on_screen(input logic [X_W:0] x, input logic [Y_W:0] y);
        return (x < X_END) && (y < Y_END);
    endfunction

endpackage

// File: rtl/object_draw_pipe.sv
// Two-stage pixel delay line: stage 1 lines up with the object ROM read, stage 2
// registers the VGA write (coordinates, colour, clipped plot strobe).
module object_draw_pipe
    import object_draw_pkg::*;
#(
    parameter int unsigned n  = 3,
    parameter int unsigned Mn = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pix_valid,
    input  logic [Mn-1:0]    pix_cnt,
    input  logic [X_W-1:0]   x_origin,
    input  logic [Y_W-1:0]   y_origin,
    input  logic [n-1:0]     pix_colour,
    input  logic             pix_keep,
    output logic [X_W-1:0]   vga_x,
    output logic [Y_W-1:0]   vga_y,
    output logic [n-1:0]     vga_colour,
    output logic             vga_plot
);

    localparam int unsigned HALF = Mn / 2;

    logic [HALF-1:0]  col;
    logic [HALF-1:0]  row;

    logic             valid1_q, valid1_d;
    logic [X_W:0]     x1_q, x1_d;
    logic [Y_W:0]     y1_q, y1_d;

    logic [X_W-1:0]   vga_x_q, vga_x_d;
    logic [Y_W-1:0]   vga_y_q, vga_y_d;
    logic [n-1:0]     vga_colour_q, vga_colour_d;
    logic             vga_plot_q, vga_plot_d;

    always_comb begin
        col = pix_cnt[HALF-1:0];
        row = pix_cnt[Mn-1:HALF];

        valid1_d = pix_valid;
        x1_d     = {1'b0, x_origin} + {{(X_W + 1 - HALF){1'b0}}, col};
        y1_d     = {1'b0, y_origin} + {{(Y_W + 1 - HALF){1'b0}}, row};

        // Stage 2 meets rom_q for the same pixel; off-screen sums are dropped, never wrapped.
        vga_x_d      = x1_q[X_W-1:0];
        vga_y_d      = y1_q[Y_W-1:0];
        vga_colour_d = pix_colour;
        vga_plot_d   = valid1_q && pix_keep && on_screen(x1_q, y1_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid1_q     <= 1'b0;
            x1_q         <= '0;
            y1_q         <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
        end else begin
            valid1_q     <= valid1_d;
            x1_q         <= x1_d;
            y1_q         <= y1_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
        end
    end

    always_comb begin
        vga_x      = vga_x_q;
        vga_y      = vga_y_q;
        vga_colour = vga_colour_q;
        vga_plot   = vga_plot_q;
    end

endmodule

// File: rtl/object_drawer.sv
// Sprite drawer: walks an external object ROM and emits one VGA pixel write per entry.
// Build option: OBJECT_DRAWER_TRANSPARENT_EN suppresses the plot strobe for colour-0 pixels.
module object_drawer
    import object_draw_pkg::*;
#(
    parameter int unsigned n  = 3,
    parameter int unsigned Mn = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [X_W-1:0]   x_origin,
    input  logic [Y_W-1:0]   y_origin,
    output logic             busy,
    output logic             done,
    output logic [Mn-1:0]    rom_addr,
    input  logic [n-1:0]     rom_q,
    output logic [X_W-1:0]   vga_x,
    output logic [Y_W-1:0]   vga_y,
    output logic [n-1:0]     vga_colour,
    output logic             vga_plot
);

    draw_state_e      state_q, state_d;
    logic [Mn-1:0]    cnt_q, cnt_d;
    logic             flush_q, flush_d;
    logic [X_W-1:0]   x_org_q, x_org_d;
    logic [Y_W-1:0]   y_org_q, y_org_d;
    logic             pix_keep;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flush_d = flush_q;
        x_org_d = x_org_q;
        y_org_d = y_org_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_DRAW;
                    cnt_d   = '0;
                    x_org_d = x_origin;
                    y_org_d = y_origin;
                end
            end
            ST_DRAW: begin
                // cnt wraps to 0 on the last pixel, so rom_addr idles at 0 afterwards.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = ST_FLUSH;
                    flush_d = 1'b0;
                end
            end
            ST_FLUSH: begin
                flush_d = ~flush_q;
                if (flush_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            flush_q <= 1'b0;
            x_org_q <= '0;
            y_org_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            x_org_q <= x_org_d;
            y_org_q <= y_org_d;
        end
    end

    always_comb begin
        busy     = (state_q != ST_IDLE);
        done     = (state_q == ST_DONE);
        rom_addr = cnt_q;
    end

`ifdef OBJECT_DRAWER_TRANSPARENT_EN
    always_comb pix_keep = |rom_q;
`else
    always_comb pix_keep = 1'b1;
`endif

    object_draw_pipe #(
        .n  (n),
        .Mn (Mn)
    ) u_pipe (
        .clock      (clock),
        .reset      (reset),
        .pix_valid  (state_q == ST_DRAW),
        .pix_cnt    (cnt_q),
        .x_origin   (x_org_q),
        .y_origin   (y_org_q),
        .pix_colour (rom_q),
        .pix_keep   (pix_keep),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

endmodule

// File: tb/tb_object_drawer.sv
// Self-checking bench for object_drawer: per-cycle behavioural model plus literal scenario checks.
// Honours OBJECT_DRAWER_TRANSPARENT_EN when deciding which pixels must be plotted.
module tb_object_drawer;

    localparam int unsigned N  = 3;
    localparam int unsigned MN = 6;
`ifdef OBJECT_DRAWER_TRANSPARENT_EN
    localparam bit TR = 1'b1;
`else
    localparam bit TR = 1'b0;
`endif
    localparam int FULL = TR ? 56 : 64;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    x_origin;
    logic [6:0]    y_origin;
    logic          busy;
    logic          done;
    logic [MN-1:0] rom_addr;
    logic [N-1:0]  rom_q;
    logic [7:0]    vga_x;
    logic [6:0]    vga_y;
    logic [N-1:0]  vga_colour;
    logic          vga_plot;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    int            plot_seen = 0;
    int            done_seen = 0;
    int            rom_mode  = 0;
    logic [N-1:0]  rom_tbl [64];

    object_drawer #(.n(N), .Mn(MN)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .x_origin   (x_origin),
        .y_origin   (y_origin),
        .busy       (busy),
        .done       (done),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [N-1:0] rom_fn(input int a);
        case (rom_mode)
            0:       return N'((a % 8) + 1);
            1:       return (a % 2 == 0) ? '0 : N'(((a / 2) % 7) + 1);
            default: return rom_tbl[a];
        endcase
    endfunction

    always @(posedge clock) rom_q <= rom_fn(int'(rom_addr));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Behavioural model: a draw accepted in cycle s fixes every output by age = cyc - s.
    bit m_active = 1'b0;
    int m_start  = 0;
    int m_ox, m_oy, age, pc, ex, ey, e_col;
    bit e_plot;

    always @(negedge clock) begin
        if (vga_plot === 1'b1) plot_seen++;
        if (done === 1'b1) done_seen++;
        if (reset) begin
            m_active = 1'b0;
            chk("rst_busy", 32'(busy), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_plot", 32'(vga_plot), 0);
            chk("rst_rom_addr", 32'(rom_addr), 0);
            chk("rst_vga_x", 32'(vga_x), 0);
            chk("rst_vga_y", 32'(vga_y), 0);
            chk("rst_colour", 32'(vga_colour), 0);
        end else begin
            age = cyc - m_start;
            if (m_active && age >= 68) m_active = 1'b0;
            if (!m_active) begin
                chk("idle_busy", 32'(busy), 0);
                chk("idle_done", 32'(done), 0);
                chk("idle_plot", 32'(vga_plot), 0);
                chk("idle_rom_addr", 32'(rom_addr), 0);
                if (start === 1'b1) begin
                    m_active = 1'b1;
                    m_start  = cyc;
                    m_ox     = int'(x_origin);
                    m_oy     = int'(y_origin);
                end
            end else begin
                chk("busy", 32'(busy), (age >= 1 && age <= 67) ? 1 : 0);
                chk("done", 32'(done), (age == 67) ? 1 : 0);
                chk("rom_addr", 32'(rom_addr), (age >= 1 && age <= 64) ? age - 1 : 0);
                e_plot = 1'b0;
                if (age >= 3 && age <= 66) begin
                    pc     = age - 3;
                    ex     = m_ox + pc % 8;
                    ey     = m_oy + pc / 8;
                    e_col  = int'(rom_fn(pc));
                    e_plot = (ex < 160) && (ey < 120) && !(TR && e_col == 0);
                end
                chk("plot", 32'(vga_plot), e_plot ? 1 : 0);
                if (e_plot) begin
                    chk("vga_x", 32'(vga_x), ex);
                    chk("vga_y", 32'(vga_y), ey);
                    chk("vga_colour", 32'(vga_colour), e_col);
                end
            end
        end
    end

    task automatic step(input int k);
        repeat (k) @(posedge clock);
        #1;
    endtask

    task automatic goto_cycle(input int t);
        while (cyc < t) step(1);
    endtask

    task automatic pulse_start(input int x, input int y);
        x_origin = 8'(x);
        y_origin = 7'(y);
        start    = 1'b1;
        step(1);
        start    = 1'b0;
    endtask

    int s, p0, d0;

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        x_origin = '0;
        y_origin = '0;
        step(3);
        reset = 1'b0;
        step(2);

        // Origin (10,20), colour = addr[2:0]+1.
        rom_mode = 0;
        p0 = plot_seen; d0 = done_seen; s = cyc;
        pulse_start(10, 20);
        goto_cycle(s + 3);
        @(negedge clock);
        chk("s1_first_plot", 32'(vga_plot), 1);
        chk("s1_first_x", 32'(vga_x), 10);
        chk("s1_first_y", 32'(vga_y), 20);
        chk("s1_first_colour", 32'(vga_colour), 1);
        goto_cycle(s + 66);
        @(negedge clock);
        chk("s1_last_plot", 32'(vga_plot), TR ? 0 : 1);
        chk("s1_last_x", 32'(vga_x), 17);
        chk("s1_last_y", 32'(vga_y), 27);
        chk("s1_last_colour", 32'(vga_colour), 0);
        goto_cycle(s + 67);
        @(negedge clock);
        chk("s1_done", 32'(done), 1);
        goto_cycle(s + 70);
        chk("s1_plots", plot_seen - p0, FULL);
        chk("s1_dones", done_seen - d0, 1);

        // Near the bottom-right corner: 4 columns x 3 rows survive clipping.
        p0 = plot_seen; d0 = done_seen; s = cyc;
        pulse_start(156, 117);
        goto_cycle(s + 67);
        @(negedge clock);
        chk("s2_done", 32'(done), 1);
        goto_cycle(s + 70);
        chk("s2_plots", plot_seen - p0, 12);
        chk("s2_dones", done_seen - d0, 1);

        // Second start mid-draw must be ignored, origin must not move.
        p0 = plot_seen; d0 = done_seen; s = cyc;
        pulse_start(40, 30);
        goto_cycle(s + 30);
        pulse_start(50, 50);
        goto_cycle(s + 75);
        chk("s3_plots", plot_seen - p0, FULL);
        chk("s3_dones", done_seen - d0, 1);

        // Reset at age 40 abandons the draw; a fresh draw then completes normally.
        p0 = plot_seen; d0 = done_seen; s = cyc;
        pulse_start(20, 10);
        goto_cycle(s + 40);
        reset = 1'b1;
        @(negedge clock);
        chk("s4_rst_busy", 32'(busy), 0);
        chk("s4_rst_plot", 32'(vga_plot), 0);
        chk("s4_rst_addr", 32'(rom_addr), 0);
        step(2);
        reset = 1'b0;
        step(1);
        chk("s4_partial_plots", plot_seen - p0, TR ? 33 : 37);
        chk("s4_no_done", done_seen - d0, 0);
        p0 = plot_seen; d0 = done_seen; s = cyc;
        pulse_start(20, 10);
        goto_cycle(s + 70);
        chk("s4_plots", plot_seen - p0, FULL);
        chk("s4_dones", done_seen - d0, 1);

        // Black at every even address.
        rom_mode = 1;
        step(2);
        p0 = plot_seen; d0 = done_seen; s = cyc;
        pulse_start(0, 0);
        goto_cycle(s + 70);
        chk("s5_plots", plot_seen - p0, TR ? 32 : 64);
        chk("s5_dones", done_seen - d0, 1);

        // Start held high for 200 cycles: back-to-back draws every 68 cycles.
        rom_mode = 0;
        step(2);
        p0 = plot_seen; d0 = done_seen; s = cyc;
        x_origin = 8'd5;
        y_origin = 7'd5;
        start    = 1'b1;
        goto_cycle(s + 67);
        @(negedge clock);
        chk("s6_done_a", 32'(done), 1);
        goto_cycle(s + 68);
        @(negedge clock);
        chk("s6_idle_a", 32'(busy), 0);
        goto_cycle(s + 135);
        @(negedge clock);
        chk("s6_done_b", 32'(done), 1);
        goto_cycle(s + 136);
        @(negedge clock);
        chk("s6_idle_b", 32'(busy), 0);
        goto_cycle(s + 200);
        start = 1'b0;
        goto_cycle(s + 215);
        chk("s6_plots", plot_seen - p0, 3 * FULL);
        chk("s6_dones", done_seen - d0, 3);

        // Randomised draws: random ROM, origins, stray starts and occasional reset.
        for (int it = 0; it < 8; it++) begin
            int rst_at;
            rom_mode = 2;
            for (int a = 0; a < 64; a++) rom_tbl[a] = N'($urandom_range(0, 7));
            step(2);
            rst_at = (it % 3 == 1) ? int'($urandom_range(5, 70)) : -1;
            pulse_start(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)));
            for (int k = 1; k <= 80; k++) begin
                x_origin = 8'($urandom_range(0, 255));
                y_origin = 7'($urandom_range(0, 127));
                start    = ($urandom_range(0, 7) == 0);
                reset    = (k == rst_at);
                step(1);
            end
            start = 1'b0;
            reset = 1'b0;
            step(75);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
